uart_rx_unit: RTL

UART_RX_UNIT -- requirements
Module: uart_rx_unit

---
 rtl/uart_rx_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_unit.sv
// UART receiver: 16x oversampled start/data/stop framing into a small byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and a parity_err output.
module uart_rx_unit #(
    parameter int DVSR    = 163,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_empty,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            overrun
);
    localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 2 ** FIFO_W;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic            rx_meta_q, rx_sync_q;
    logic [CW-1:0]   cnt_q;
    logic            tick;
    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            frame_err_q, frame_err_d;
    logic            pbad_q, pbad_d;
    logic            perr_q, perr_d;
    logic            push;

    logic [DBIT-1:0] mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_W:0]   count_q;
    logic            overrun_q;
    logic            full, rd_ok, wr_ok, ovf;

    assign tick = (cnt_q == CW'(DVSR - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            cnt_q     <= tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        pbad_d      = pbad_q;
        perr_d      = 1'b0;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                s_d = '0;
                if (!rx_sync_q) state_d = START;
            end
            START: if (tick) begin
                if (s_q == SW'(7)) begin
                    s_d = '0;
                    n_d = '0;
                    pbad_d = 1'b0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
            DATA: if (tick) begin
                if (s_q == SW'(15)) begin
                    s_d = '0;
                    b_d = {rx_sync_q, b_q[DBIT-1:1]};
                    if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: the parity bit must equal the XOR of the data bits.
            PARITY: if (tick) begin
                if (s_q == SW'(15)) begin
                    s_d = '0;
                    state_d = STOP;
                    if (rx_sync_q != ^b_q) begin
                        pbad_d = 1'b1;
                        perr_d = 1'b1;
                    end
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
`endif
            STOP: if (tick) begin
                if (s_q == SW'(SB_TICK - 1)) begin
                    s_d = '0;
                    state_d = IDLE;
                    if (rx_sync_q) push = !pbad_q;
                    else           frame_err_d = 1'b1;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            pbad_q      <= 1'b0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            pbad_q      <= pbad_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A push into a full FIFO is still accepted when the head is popped in the same cycle.
    assign full  = (count_q == (FIFO_W+1)'(DEPTH));
    assign rd_ok = rd && (count_q != '0);
    assign wr_ok = push && (!full || rd_ok);
    assign ovf   = push && full && !rd_ok;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= b_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + FIFO_W'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + FIFO_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (FIFO_W+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_W+1)'(1);
                default: count_q <= count_q;
            endcase
            if (ovf)        overrun_q <= 1'b1;
            else if (rd_ok) overrun_q <= 1'b0;
        end
    end

    assign rx_empty  = (count_q == '0);
    assign rx_data   = rx_empty ? '0 : mem[rd_ptr_q];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
